// File: rtl/rts_packer_if.sv
// RTS/RTR bundle for rts_packer: narrow element side in, wide word side out.
// Extra IN_LAST / OUT_CNT signals exist only with PACKER_FLUSH_EN.
interface rts_packer_if #(
  parameter int WORDLENGTH = 8,
  parameter int LOG2_RATIO = 2
);
  localparam int RATIO = 1 << LOG2_RATIO;

  logic                        IN_RTS;
  logic                        IN_RTR;
  logic [WORDLENGTH-1:0]       IN_DAT;
  logic                        OUT_RTS;
  logic                        OUT_RTR;
  logic [WORDLENGTH*RATIO-1:0] OUT_DAT;
`ifdef PACKER_FLUSH_EN
  logic                        IN_LAST;
  logic [LOG2_RATIO:0]         OUT_CNT;

  modport master (
    output IN_RTS, IN_DAT, IN_LAST, OUT_RTR,
    input  IN_RTR, OUT_RTS, OUT_DAT, OUT_CNT
  );
  modport slave (
    input  IN_RTS, IN_DAT, IN_LAST, OUT_RTR,
    output IN_RTR, OUT_RTS, OUT_DAT, OUT_CNT
  );
`else
  modport master (
    output IN_RTS, IN_DAT, OUT_RTR,
    input  IN_RTR, OUT_RTS, OUT_DAT
  );
  modport slave (
    input  IN_RTS, IN_DAT, OUT_RTR,
    output IN_RTR, OUT_RTS, OUT_DAT
  );
`endif
endinterface

// File: rtl/rts_packer.sv
// Packs 2^LOG2_RATIO elements into one wide word, lane 0 first.
// Optional PACKER_FLUSH_EN: IN_LAST closes a short, zero-padded word.
module rts_packer #(
  parameter int WORDLENGTH = 8,
  parameter int LOG2_RATIO = 2
) (
  input logic        clk,
  input logic        rst_,
  rts_packer_if.slave bus
);
  localparam int W     = WORDLENGTH;
  localparam int RATIO = 1 << LOG2_RATIO;
  localparam logic [LOG2_RATIO-1:0] LAST =
    LOG2_RATIO'(RATIO - 1);

  logic [LOG2_RATIO-1:0]  cnt;
  logic [(RATIO-1)*W-1:0] asm_q;
  logic                   vld;
  logic [RATIO*W-1:0]     dat;
  logic [RATIO*W-1:0]     lanes;
  logic [RATIO*W-1:0]     word;
  logic                   closing;
  logic                   in_xfc;
  logic                   out_xfc;
`ifdef PACKER_FLUSH_EN
  logic [LOG2_RATIO:0]    ocnt;

  assign closing     = (cnt == LAST) | bus.IN_LAST;
  assign bus.OUT_CNT = ocnt;
`else
  assign closing     = (cnt == LAST);
`endif

  assign in_xfc      = bus.IN_RTS & bus.IN_RTR;
  assign out_xfc     = vld & bus.OUT_RTR;
  assign bus.IN_RTR  = ~closing | ~vld | bus.OUT_RTR;
  assign bus.OUT_RTS = vld;
  assign bus.OUT_DAT = dat;

  // Top lane padded with zero so short words come out clean.
  assign lanes = {W'(0), asm_q};

  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(cnt))
        word[i*W +: W] = bus.IN_DAT;
      else if (i < int'(cnt))
        word[i*W +: W] = lanes[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt   <= '0;
      asm_q <= '0;
      vld   <= 1'b0;
      dat   <= '0;
`ifdef PACKER_FLUSH_EN
      ocnt  <= '0;
`endif
    end else begin
      if (out_xfc)
        vld <= 1'b0;
      if (in_xfc) begin
        if (closing) begin
          dat  <= word;
          vld  <= 1'b1;
          cnt  <= '0;
`ifdef PACKER_FLUSH_EN
          ocnt <= {1'b0, cnt} + 1'b1;
`endif
        end else begin
          for (int i = 0; i < RATIO - 1; i++)
            if (cnt == LOG2_RATIO'(i))
              asm_q[i*W +: W] <= bus.IN_DAT;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rts_packer.sv
// Directed and randomised-handshake bench for rts_packer.
// Runs a RATIO=4 and a RATIO=2 instance side by side.
module tb_rts_packer;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  rts_packer_if #(.WORDLENGTH(8), .LOG2_RATIO(2)) b4 ();
  rts_packer_if #(.WORDLENGTH(8), .LOG2_RATIO(1)) b2 ();

  rts_packer #(.WORDLENGTH(8), .LOG2_RATIO(2)) u4 (
    .clk(clk), .rst_(rst_), .bus(b4.slave)
  );
  rts_packer #(.WORDLENGTH(8), .LOG2_RATIO(1)) u2 (
    .clk(clk), .rst_(rst_), .bus(b2.slave)
  );

  int checks = 0;
  int passed = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    b4.IN_RTS = 0; b4.IN_DAT = '0; b4.OUT_RTR = 0;
    b2.IN_RTS = 0; b2.IN_DAT = '0; b2.OUT_RTR = 0;
`ifdef PACKER_FLUSH_EN
    b4.IN_LAST = 0; b2.IN_LAST = 0;
`endif
    repeat (2) tick;
    checks++;
    if (b4.OUT_RTS !== 1'b0)
      $display("FAIL reset_rts got=%b exp=0", b4.OUT_RTS);
    else passed++;
    checks++;
    if (b4.OUT_DAT !== 32'h0)
      $display("FAIL reset_dat got=%h exp=0", b4.OUT_DAT);
    else passed++;
    checks++;
    if (b4.IN_RTR !== 1'b1)
      $display("FAIL reset_rtr got=%b exp=1", b4.IN_RTR);
    else passed++;
    checks++;
    if (b2.OUT_RTS !== 1'b0)
      $display("FAIL reset_rts2 got=%b exp=0", b2.OUT_RTS);
    else passed++;
`ifdef PACKER_FLUSH_EN
    checks++;
    if (b4.OUT_CNT !== 3'd0)
      $display("FAIL reset_cnt got=%0d exp=0", b4.OUT_CNT);
    else passed++;
`endif
    @(negedge clk);
    rst_ = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    b4.OUT_RTR = 1;
    b4.IN_RTS = 1;
    for (int i = 0; i < 8; i++) begin
      b4.IN_DAT = 8'(i);
      #1;
      checks++;
      if (b4.IN_RTR !== 1'b1)
        $display("FAIL b2b_rtr i=%0d got=%b exp=1", i, b4.IN_RTR);
      else passed++;
      checks++;
      if (b4.OUT_RTS !== (i == 4))
        $display("FAIL b2b_rts i=%0d got=%b exp=%b",
                 i, b4.OUT_RTS, (i == 4));
      else passed++;
      if (i == 4) begin
        checks++;
        if (b4.OUT_DAT !== 32'h03020100)
          $display("FAIL b2b_w0 got=%h exp=03020100", b4.OUT_DAT);
        else passed++;
      end
      tick;
    end
    b4.IN_RTS = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h07060504)
      $display("FAIL b2b_w1 got=%b/%h exp=1/07060504",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
`ifdef PACKER_FLUSH_EN
    checks++;
    if (b4.OUT_CNT !== 3'd4)
      $display("FAIL b2b_cnt got=%0d exp=4", b4.OUT_CNT);
    else passed++;
`endif
    tick;
    checks++;
    if (b4.OUT_RTS !== 1'b0 || b4.OUT_DAT !== 32'h07060504)
      $display("FAIL b2b_drain got=%b/%h exp=0/07060504",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
  endtask

  task automatic test_backpressure;
    b4.OUT_RTR = 0;
    b4.IN_RTS = 1;
    for (int i = 0; i < 7; i++) begin
      b4.IN_DAT = 8'(8'h10 + i);
      #1;
      checks++;
      if (b4.IN_RTR !== 1'b1)
        $display("FAIL bp_rtr i=%0d got=%b exp=1", i, b4.IN_RTR);
      else passed++;
      if (i >= 4) begin
        checks++;
        if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h13121110)
          $display("FAIL bp_hold i=%0d got=%b/%h exp=1/13121110",
                   i, b4.OUT_RTS, b4.OUT_DAT);
        else passed++;
      end
      tick;
    end
    b4.IN_DAT = 8'h17;
    repeat (2) begin
      #1;
      checks++;
      if (b4.IN_RTR !== 1'b0)
        $display("FAIL bp_stall got=%b exp=0", b4.IN_RTR);
      else passed++;
      checks++;
      if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h13121110)
        $display("FAIL bp_stable got=%b/%h exp=1/13121110",
                 b4.OUT_RTS, b4.OUT_DAT);
      else passed++;
      tick;
    end
    b4.OUT_RTR = 1;
    #1;
    checks++;
    if (b4.IN_RTR !== 1'b1)
      $display("FAIL bp_release got=%b exp=1", b4.IN_RTR);
    else passed++;
    tick;
    b4.IN_RTS = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h17161514)
      $display("FAIL bp_next got=%b/%h exp=1/17161514",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    tick;
    checks++;
    if (b4.OUT_RTS !== 1'b0)
      $display("FAIL bp_drain got=%b exp=0", b4.OUT_RTS);
    else passed++;
  endtask

  task automatic test_random;
    int sent = 0;
    int words = 0;
    int cyc = 0;
    bit hold_chk = 0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    while (words < 100 && cyc < 4000) begin
      b4.IN_RTS = (sent < 400) && ($urandom_range(0, 1) == 1);
      b4.IN_DAT = b4.IN_RTS ? 8'(sent) : 8'($urandom);
      b4.OUT_RTR = ($urandom_range(0, 1) == 1);
      #1;
      if (hold_chk) begin
        checks++;
        if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== held)
          $display("FAIL rnd_hold got=%b/%h exp=1/%h",
                   b4.OUT_RTS, b4.OUT_DAT, held);
        else passed++;
      end
      if (b4.OUT_RTS && b4.OUT_RTR) begin
        exp = {8'(4*words+3), 8'(4*words+2),
               8'(4*words+1), 8'(4*words)};
        checks++;
        if (b4.OUT_DAT !== exp)
          $display("FAIL rnd_word w=%0d got=%h exp=%h",
                   words, b4.OUT_DAT, exp);
        else passed++;
        words++;
      end
      hold_chk = b4.OUT_RTS && !b4.OUT_RTR;
      held = b4.OUT_DAT;
      if (b4.IN_RTS && b4.IN_RTR) sent++;
      tick;
      cyc++;
    end
    b4.IN_RTS = 0;
    b4.OUT_RTR = 1;
    checks++;
    if (words !== 100)
      $display("FAIL rnd_count got=%0d exp=100", words);
    else passed++;
    tick;
  endtask

  task automatic test_async_reset;
    b4.OUT_RTR = 0;
    b4.IN_RTS = 1;
    for (int i = 0; i < 6; i++) begin
      b4.IN_DAT = 8'(8'h30 + i);
      tick;
    end
    b4.IN_RTS = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h33323130)
      $display("FAIL ar_pre got=%b/%h exp=1/33323130",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    #1;
    rst_ = 1'b0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b0 || b4.OUT_DAT !== 32'h0)
      $display("FAIL ar_clear got=%b/%h exp=0/0",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    @(negedge clk);
    rst_ = 1'b1;
    tick;
    b4.OUT_RTR = 1;
    b4.IN_RTS = 1;
    for (int i = 0; i < 4; i++) begin
      b4.IN_DAT = 8'(8'hA0 + i);
      tick;
    end
    b4.IN_RTS = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'hA3A2A1A0)
      $display("FAIL ar_resume got=%b/%h exp=1/a3a2a1a0",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    tick;
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush;
    b4.OUT_RTR = 1;
    b4.IN_RTS = 1;
    for (int i = 1; i <= 3; i++) begin
      b4.IN_DAT = 8'(i);
      b4.IN_LAST = (i == 3);
      tick;
    end
    b4.IN_RTS = 0;
    b4.IN_LAST = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h00030201)
      $display("FAIL fl_short got=%b/%h exp=1/00030201",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    checks++;
    if (b4.OUT_CNT !== 3'd3)
      $display("FAIL fl_cnt3 got=%0d exp=3", b4.OUT_CNT);
    else passed++;
    tick;
    b4.IN_RTS = 1;
    b4.IN_DAT = 8'h04;
    b4.IN_LAST = 1;
    tick;
    b4.IN_RTS = 0;
    b4.IN_LAST = 0;
    #1;
    checks++;
    if (b4.OUT_RTS !== 1'b1 || b4.OUT_DAT !== 32'h00000004)
      $display("FAIL fl_single got=%b/%h exp=1/00000004",
               b4.OUT_RTS, b4.OUT_DAT);
    else passed++;
    checks++;
    if (b4.OUT_CNT !== 3'd1)
      $display("FAIL fl_cnt1 got=%0d exp=1", b4.OUT_CNT);
    else passed++;
    tick;
  endtask
`endif

  task automatic test_ratio2;
    logic [7:0] d [4];
    d = '{8'hAB, 8'hCD, 8'hEF, 8'h12};
    b2.OUT_RTR = 1;
    b2.IN_RTS = 1;
    for (int i = 0; i < 4; i++) begin
      b2.IN_DAT = d[i];
      #1;
      if (i == 2) begin
        checks++;
        if (b2.OUT_RTS !== 1'b1 || b2.OUT_DAT !== 16'hCDAB)
          $display("FAIL r2_w0 got=%b/%h exp=1/cdab",
                   b2.OUT_RTS, b2.OUT_DAT);
        else passed++;
      end
      tick;
    end
    b2.IN_RTS = 0;
    #1;
    checks++;
    if (b2.OUT_RTS !== 1'b1 || b2.OUT_DAT !== 16'h12EF)
      $display("FAIL r2_w1 got=%b/%h exp=1/12ef",
               b2.OUT_RTS, b2.OUT_DAT);
    else passed++;
    tick;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_async_reset();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    test_ratio2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
